// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: funct3 encodings,
// FSM states and the latched request record.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   // Unsigned-load encodings are meaningless for stores; 011/110/111 are never legal.
   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = we;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane steering: merges store data into the old word and
// extracts the sign/zero-extended load value from it.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] old_word_i,
   output logic [31:0] store_word_o,
   output logic [31:0] load_data_o,
   output logic        misalign_o
);

   logic [4:0]  shamt_s;
   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign shamt_s = {lane_i, 3'b000};
   assign byte_s  = 8'(old_word_i >> shamt_s);
   assign half_s  = lane_i[1] ? old_word_i[31:16] : old_word_i[15:0];

   // Lane merge for stores and extension for loads, selected by access size.
   always_comb begin
      store_word_o = old_word_i;
      load_data_o  = 32'h0000_0000;
      misalign_o   = 1'b0;
      case (funct3_i)
         F3_B, F3_BU: begin
            store_word_o = (old_word_i & ~(32'h0000_00FF << shamt_s))
                         | ({24'h00_0000, wdata_i[7:0]} << shamt_s);
            if (funct3_i == F3_B) begin
               load_data_o = {{24{byte_s[7]}}, byte_s};
            end else begin
               load_data_o = {24'h00_0000, byte_s};
            end
         end
         F3_H, F3_HU: begin
            misalign_o = lane_i[0];
            if (lane_i[1]) begin
               store_word_o = {wdata_i[15:0], old_word_i[15:0]};
            end else begin
               store_word_o = {old_word_i[31:16], wdata_i[15:0]};
            end
            if (funct3_i == F3_H) begin
               load_data_o = {{16{half_s[15]}}, half_s};
            end else begin
               load_data_o = {16'h0000, half_s};
            end
         end
         F3_W: begin
            misalign_o   = (lane_i != 2'b00);
            store_word_o = wdata_i;
            load_data_o  = old_word_i;
         end
         default: begin
            store_word_o = old_word_i;
            load_data_o  = 32'h0000_0000;
            misalign_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: request handshake, programmable
// wait states, byte/half/word access to a word RAM, registered response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dmem_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   dmem_req_t   req_q, req_d, live_req_s, acc_req_s;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        req_ready_q, rsp_valid_q;

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0] idx_s;
   logic [31:0]      old_word_s, store_word_s, load_data_s;
   logic             misalign_s, bad_f3_s, oor_s, acc_err_s;
   logic             access_s, mem_we_s;

   assign live_req_s = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

   // With zero wait states the access happens on the accept edge, so it must use the live inputs.
   assign acc_req_s  = (state_q == IDLE) ? live_req_s : req_q;
   assign idx_s      = acc_req_s.addr[IDX_W+1:2];
   assign old_word_s = mem_q[idx_s];

   dmem_lane_align u_lane_align (
      .funct3_i     (acc_req_s.funct3),
      .lane_i       (acc_req_s.addr[1:0]),
      .wdata_i      (acc_req_s.wdata),
      .old_word_i   (old_word_s),
      .store_word_o (store_word_s),
      .load_data_o  (load_data_s),
      .misalign_o   (misalign_s)
   );

   assign bad_f3_s  = f3_illegal(acc_req_s.we, acc_req_s.funct3);
   assign oor_s     = (acc_req_s.addr >> (IDX_W + 2)) != 32'd0;
   assign acc_err_s = misalign_s | bad_f3_s | oor_s;
   assign access_s  = (state_d == RESP) && (state_q != RESP);
   assign mem_we_s  = access_s && acc_req_s.we && !acc_err_s && !rst;

   // Next-state, wait counter, request latch and response data.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               req_d = live_req_s;
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d = RESP;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               rdata_d = 32'h0000_0000;
               err_d   = 1'b0;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (access_s) begin
         err_d   = acc_err_s;
         rdata_d = (acc_err_s || acc_req_s.we) ? 32'h0000_0000 : load_data_s;
      end else begin
         err_d = err_d;
      end
   end

   // State and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         req_q       <= '0;
         rdata_q     <= 32'h0000_0000;
         err_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= (state_d == IDLE);
         rsp_valid_q <= (state_d == RESP);
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[idx_s] <= store_word_s;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
